// File: rtl/mux1hot_arb_pkg.sv
// mux1hot_arb_pkg: shared state type and round-robin helpers for mux1hot_rr_arbiter
//   rr_pick(req, ptr, n) : one-hot winner, scanning req from ptr upward with wrap at n
//   onehot2bin(oh)       : binary index of a one-hot vector (0 when oh is zero)
package mux1hot_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_PKT} arb_state_e;

    localparam int MAX_INPUTS = 32;

    function automatic logic [MAX_INPUTS-1:0] rr_pick(
        input logic [MAX_INPUTS-1:0] req,
        input int                    ptr,
        input int                    n
    );
        logic [MAX_INPUTS-1:0] g;
        int idx;
        g = '0;
        for (int k = 0; k < MAX_INPUTS; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (k < n && g == '0 && req[idx[4:0]]) g[idx[4:0]] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [4:0] onehot2bin(input logic [MAX_INPUTS-1:0] oh);
        logic [4:0] b;
        b = '0;
        for (int k = 0; k < MAX_INPUTS; k++)
            if (oh[k]) b = b | 5'(k);
        return b;
    endfunction

endpackage

// File: rtl/Mux1hot.sv
// Mux1hot: one-hot select of one WIDTH-bit lane out of INPUTS lanes
//   sel_i  : one-hot (or zero) lane select
//   data_i : lane i at data_i[i*WIDTH +: WIDTH]
//   data_o : selected lane, zero when sel_i is zero
module Mux1hot #(
    parameter int INPUTS = 2,
    parameter int WIDTH  = 1
) (
    input  logic [INPUTS-1:0]       sel_i,
    input  logic [WIDTH*INPUTS-1:0] data_i,
    output logic [WIDTH-1:0]        data_o
);

    always_comb begin
        data_o = '0;
        for (int i = 0; i < INPUTS; i++)
            data_o = data_o | (data_i[i*WIDTH +: WIDTH] & {WIDTH{sel_i[i]}});
    end

endmodule

// File: rtl/mux1hot_rr_arbiter.sv
// mux1hot_rr_arbiter: round-robin valid/ready arbiter with registered one-hot grant
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_last    : per-requester valid and end-of-packet
//   in_data             : requester i at in_data[i*WIDTH +: WIDTH]
//   in_ready            : per-requester ready (one-hot or zero)
//   out_valid/out_data  : shared output channel, out_ready from downstream
//   gnt/gnt_id          : registered one-hot grant and its binary index
//   Optional macro ARB_PKT_LOCK_EN: hold grant until a transfer with in_last set.
module mux1hot_rr_arbiter
    import mux1hot_arb_pkg::*;
#(
    parameter int INPUTS = 2,
    parameter int WIDTH  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [INPUTS-1:0]         in_valid,
    input  logic [INPUTS-1:0]         in_last,
    input  logic [WIDTH*INPUTS-1:0]   in_data,
    output logic [INPUTS-1:0]         in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      out_ready,
    output logic [INPUTS-1:0]         gnt,
    output logic [$clog2(INPUTS)-1:0] gnt_id
);

    localparam int IW = $clog2(INPUTS);

    arb_state_e            state_q, state_d;
    logic [INPUTS-1:0]     gnt_q, gnt_d;
    logic [IW-1:0]         gnt_id_q, gnt_id_d, ptr_q, ptr_d, ptr_nxt;
    logic [MAX_INPUTS-1:0] pick_cur, pick_nxt;
    logic                  xfer, ends, locked;

    // Pointer after the current grant ends: one past the granted requester.
    assign ptr_nxt  = (gnt_id_q == IW'(INPUTS - 1)) ? '0 : gnt_id_q + 1'b1;
    assign pick_cur = rr_pick(MAX_INPUTS'(in_valid), int'(ptr_q), INPUTS);
    assign pick_nxt = rr_pick(MAX_INPUTS'(in_valid), int'(ptr_nxt), INPUTS);

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign in_ready  = gnt_q & {INPUTS{out_ready}};
    assign out_valid = |(in_valid & gnt_q);
    assign xfer      = out_valid & out_ready;

`ifdef ARB_PKT_LOCK_EN
    assign ends   = xfer & in_last[gnt_id_q];
    assign locked = state_q == ARB_PKT;
`else
    logic unused_last;
    assign unused_last = ^in_last;
    assign ends        = xfer;
    assign locked      = 1'b0;
`endif

    Mux1hot #(.INPUTS(INPUTS), .WIDTH(WIDTH)) u_mux (
        .sel_i  (gnt_q),
        .data_i (in_data),
        .data_o (out_data)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        if (state_q == ARB_IDLE) begin
            if (|in_valid) begin
                state_d  = ARB_BUSY;
                gnt_d    = pick_cur[INPUTS-1:0];
                gnt_id_d = IW'(onehot2bin(pick_cur));
            end
        end else if (ends) begin
            // Re-arbitrate in the transfer cycle so back-to-back grants have no bubble.
            ptr_d    = ptr_nxt;
            state_d  = |in_valid ? ARB_BUSY : ARB_IDLE;
            gnt_d    = pick_nxt[INPUTS-1:0];
            gnt_id_d = IW'(onehot2bin(pick_nxt));
`ifdef ARB_PKT_LOCK_EN
        end else if (xfer) begin
            state_d = ARB_PKT;
`endif
        end else if (!in_valid[gnt_id_q] && !locked) begin
            state_d  = ARB_IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
        end
    end

endmodule

// File: tb/tb_mux1hot_rr_arbiter.sv
// tb_mux1hot_rr_arbiter: directed and random checks of mux1hot_rr_arbiter against a behavioural model
module tb_mux1hot_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;
`ifdef ARB_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_valid, in_last, in_ready, gnt;
    logic [N*W-1:0] in_data;
    logic           out_valid, out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     gnt_id;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: granted requester index (-1 idle), priority pointer, mid-packet flag.
    int m_gnt  = -1;
    int m_ptr  = 0;
    bit m_lock = 1'b0;

    mux1hot_rr_arbiter #(.INPUTS(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .gnt       (gnt),
        .gnt_id    (gnt_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic int pick(input int p);
        for (int k = 0; k < N; k++)
            if (in_valid[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // One clock: compare outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        logic [W-1:0] ed;
        bit ov, last;
        @(negedge clk);
        ed = '0;
        ov = 1'b0;
        if (m_gnt >= 0) begin
            ed = in_data[m_gnt*W +: W];
            ov = in_valid[m_gnt];
        end
        check("gnt", 32'(gnt), m_gnt < 0 ? 32'd0 : 32'(1 << m_gnt));
        check("gnt_id", 32'(gnt_id), m_gnt < 0 ? 32'd0 : 32'(m_gnt));
        check("out_valid", 32'(out_valid), 32'(ov));
        check("out_data", 32'(out_data), 32'(ed));
        check("in_ready", 32'(in_ready), (m_gnt >= 0 && out_ready) ? 32'(1 << m_gnt) : 32'd0);
        @(posedge clk);
        if (!rst_n) begin
            m_gnt  = -1;
            m_ptr  = 0;
            m_lock = 1'b0;
        end else if (m_gnt < 0) begin
            m_gnt = pick(m_ptr);
        end else if (ov && out_ready) begin
            last = LOCK ? in_last[m_gnt] : 1'b1;
            if (last) begin
                m_ptr  = (m_gnt + 1) % N;
                m_lock = 1'b0;
                m_gnt  = pick(m_ptr);
            end else begin
                m_lock = 1'b1;
            end
        end else if (!ov && !m_lock) begin
            m_gnt = -1;
        end
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'hA0 + 8'(i);

        // Reset held with every requester valid.
        steps(3);
        rst_n = 1'b1;
        step();
        check("first_gnt", 32'(gnt), 32'h1);

        // Rotation: one beat per cycle, in order, no bubbles.
        for (int k = 0; k < 8; k++) begin
            check("rotation", 32'(out_data), 32'(8'hA0 + 8'(k % N)));
            step();
        end

        // Backpressure on requester 2 while requester 0 waits.
        in_valid = 4'b0000;
        steps(2);
        in_valid = 4'b0100;
        step();
        in_valid  = 4'b0101;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_hold", 32'(gnt), 32'h4);
            check("bp_data", 32'(out_data), 32'hA2);
        end
        out_ready = 1'b1;
        step();
        check("bp_next", 32'(gnt), 32'h1);

        // Sparse: requester 3 transfers, pointer wraps to 0.
        in_valid = 4'b0000;
        steps(3);
        in_valid  = 4'b1000;
        out_ready = 1'b0;
        step();
        check("sparse3", 32'(gnt), 32'h8);
        out_ready = 1'b1;
        in_valid  = 4'b1001;
        step();
        check("wrap0", 32'(gnt), 32'h1);
        in_valid = 4'b0000;
        steps(2);
        check("idle", 32'(gnt), 32'h0);

        // Packet: requester 1 sends 3 beats with a 2-cycle gap, requester 2 waiting.
        in_last  = 4'b0000;
        in_valid = 4'b0010;
        step();
        in_valid = 4'b0110;
        step();
        check("pkt_beat1", 32'(gnt), LOCK ? 32'h2 : 32'h4);
        in_valid = 4'b0100;
        steps(2);
        in_valid = 4'b0110;
        step();
        in_last = 4'b0010;
        step();
        in_last  = 4'b0000;
        in_valid = 4'b0000;
        steps(4);

        // Reset in the middle of a packet drops the lock and pointer.
        in_valid = 4'b0100;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_mid", 32'(gnt), 32'h0);
        in_valid = 4'b1111;
        step();
        check("rst_ptr", 32'(gnt), 32'h1);

        // Random traffic.
        for (int k = 0; k < 2000; k++) begin
            rst_n     = ($urandom_range(63) != 0);
            in_valid  = N'($urandom);
            in_last   = N'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(3) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
